// File: rtl/charlieplex_pkg.sv
// Shared types and LED index mapping for the charlieplexed PWM driver.
package charlieplex_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // LED fed by anode `row` and cathode `cathode`; the anode pin itself is skipped in the cathode count.
    function automatic int led_index(int pins, int row, int cathode);
        return row * (pins - 1) + ((cathode < row) ? cathode : cathode - 1);
    endfunction

endpackage

// File: rtl/charlieplex_pwm_if.sv
// Brightness write port of the charlieplexed PWM driver.
interface charlieplex_pwm_if #(
    parameter int PINS = 7,
    parameter int BITS = 4
);
    localparam int AW = $clog2(PINS * (PINS - 1));

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BITS-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/charlieplex_tick.sv
// Free-running prescaler: one-cycle tick strobe every HOLD clocks.
module charlieplex_tick #(
    parameter int HOLD = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(HOLD - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/charlieplex_pwm.sv
// Charlieplexed LED PWM scanner with double-buffered brightness.
// Define CHARLIEPLEX_BLANK_EN to insert a one-tick all-off BLANK before each row.
module charlieplex_pwm
    import charlieplex_pkg::*;
#(
    parameter int PINS = 7,
    parameter int BITS = 4,
    parameter int HOLD = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    charlieplex_pwm_if.slave   wr,
    output logic [PINS-1:0]    charlieplex_oe,
    output logic [PINS-1:0]    charlieplex_o,
    output logic               frame_done
);
    localparam int LEDS = PINS * (PINS - 1);
    localparam int AW   = $clog2(LEDS);
    localparam int RW   = $clog2(PINS);
    localparam logic [AW:0]     LEDS_W   = (AW + 1)'(LEDS);
    localparam logic [RW-1:0]   ROW_LAST = RW'(PINS - 1);
    localparam logic [BITS-1:0] T_LAST   = BITS'((1 << BITS) - 2);
`ifdef CHARLIEPLEX_BLANK_EN
    localparam state_e START = BLANK;
`else
    localparam state_e START = DRIVE;
`endif

    logic tick;
    state_e state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [BITS-1:0] t_q, t_d;
    logic            last_tick, frame_done_q;
    logic [PINS-1:0] oe_q, oe_d, o_q, o_d;
    logic [BITS-1:0] wbuf_q [LEDS];
    logic [BITS-1:0] disp_q [LEDS];
    logic [BITS-1:0] disp_d [LEDS];
    logic            wr_hit;

    charlieplex_tick #(.HOLD(HOLD)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign wr_hit = wr.wr_en && ({1'b0, wr.wr_addr} < LEDS_W);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        t_d       = t_q;
        last_tick = 1'b0;
        if (tick) begin
            unique case (state_q)
                BLANK: begin
                    state_d = DRIVE;
                    t_d     = '0;
                end
                DRIVE: begin
                    if (t_q == T_LAST) begin
                        t_d       = '0;
                        last_tick = (row_q == ROW_LAST);
                        row_d     = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
`ifdef CHARLIEPLEX_BLANK_EN
                        state_d   = BLANK;
`endif
                    end else begin
                        t_d = t_q + BITS'(1);
                    end
                end
                default: state_d = START;
            endcase
        end
    end

    // Pins are computed from the buffer contents as they stand after this edge, so a
    // swap coinciding with the first DRIVE tick of row 0 already shows the new frame.
    always_comb begin
        disp_d = frame_done_q ? wbuf_q : disp_q;
        oe_d   = '0;
        o_d    = '0;
        if (state_q == DRIVE) begin
            oe_d[row_q] = 1'b1;
            o_d[row_q]  = 1'b1;
            for (int c = 0; c < PINS; c++) begin
                if (c != int'(row_q) &&
                    t_q < disp_d[AW'(led_index(PINS, int'(row_q), c))]) begin
                    oe_d[c] = 1'b1;
                end
            end
        end
    end

    // NOTE: both buffers are reset flop arrays, not RAM, because the first frame after reset must be dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEDS; i++) begin
                wbuf_q[i] <= '0;
                disp_q[i] <= '0;
            end
            state_q      <= START;
            row_q        <= '0;
            t_q          <= '0;
            frame_done_q <= 1'b0;
            oe_q         <= '0;
            o_q          <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            disp_q       <= disp_d;
            if (wr_hit) wbuf_q[wr.wr_addr] <= wr.wr_data;
            state_q      <= state_d;
            row_q        <= row_d;
            t_q          <= t_d;
            frame_done_q <= last_tick;
            oe_q         <= oe_d;
            o_q          <= o_d;
        end
    end

    assign charlieplex_oe = oe_q;
    assign charlieplex_o  = o_q;
    assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_charlieplex_pwm.sv
// Randomized self-checking bench for charlieplex_pwm against a frame/tick schedule model.
module tb_charlieplex_pwm;
    localparam int PINS = 3;
    localparam int BITS = 2;
    localparam int HOLD = 4;
    localparam int LEDS = PINS * (PINS - 1);
    localparam int MAXB = (1 << BITS) - 1;
`ifdef CHARLIEPLEX_BLANK_EN
    localparam int ROW_TICKS = 1 << BITS;
`else
    localparam int ROW_TICKS = (1 << BITS) - 1;
`endif
    localparam int FRAME_CYC = PINS * ROW_TICKS * HOLD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [PINS-1:0] oe, o;
    logic frame_done;

    always #5 clk = ~clk;

    charlieplex_pwm_if #(.PINS(PINS), .BITS(BITS)) wr_if ();

    charlieplex_pwm #(.PINS(PINS), .BITS(BITS), .HOLD(HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr            (wr_if),
        .charlieplex_oe(oe),
        .charlieplex_o (o),
        .frame_done    (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wbuf [LEDS];
    int disp [LEDS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pins k cycles after reset release; pins trail the schedule by one cycle.
    function automatic void model_pins(input int k, output int e_oe, output int e_o);
        int tk, row, slot, t, j, cath;
        e_oe = 0;
        e_o  = 0;
        if (k == 0) return;
        tk   = (k - 1) / HOLD;
        row  = (tk / ROW_TICKS) % PINS;
        slot = tk % ROW_TICKS;
`ifdef CHARLIEPLEX_BLANK_EN
        if (slot == 0) return;
        t = slot - 1;
`else
        t = slot;
`endif
        e_oe = 1 << row;
        e_o  = 1 << row;
        for (int led = 0; led < LEDS; led++) begin
            if (led / (PINS - 1) != row) continue;
            j    = led % (PINS - 1);
            cath = (j < row) ? j : j + 1;
            if (t < disp[led]) e_oe |= (1 << cath);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LEDS; i++) begin
            wbuf[i] = 0;
            disp[i] = 0;
        end
    endtask

    // Called at a negedge just after reset release; leaves the bench at a later negedge.
    task automatic run_cycles(input int ncyc);
        int e_oe, e_o, addr, data;
        bit en, swap;
        for (int k = 0; k < ncyc; k++) begin
            model_pins(k, e_oe, e_o);
            swap = (k > 0) && (k % FRAME_CYC == 0);
            check("oe", 32'(oe), e_oe);
            check("o", 32'(o), e_o);
            check("frame_done", 32'(frame_done), 32'(swap));
            en   = ($urandom_range(0, 3) == 0);
            addr = $urandom_range(0, 7);
            data = $urandom_range(0, MAXB);
            if (swap) begin
                en   = 1'b1;
                addr = 2;
            end
            wr_if.wr_en   = en;
            wr_if.wr_addr = 3'(addr);
            wr_if.wr_data = BITS'(data);
            if (swap) begin
                for (int i = 0; i < LEDS; i++) disp[i] = wbuf[i];
            end
            if (en && addr < LEDS) wbuf[addr] = data;
            @(negedge clk);
        end
        wr_if.wr_en = 1'b0;
    endtask

    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_addr = '0;
        wr_if.wr_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_oe", 32'(oe), 0);
        check("reset_o", 32'(o), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        run_cycles(250);

        // Asynchronous reset in the middle of a DRIVE tick.
        check("pre_reset_anode_on", 32'(oe != '0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_oe", 32'(oe), 0);
        check("async_reset_o", 32'(o), 0);
        check("async_reset_frame_done", 32'(frame_done), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cycles(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
